// File: rtl/pwm_sira_yoneticisi.sv
// Duty-cycle sequencer: holds a CPU-loaded threshold table and replays it,
// one entry per step, into the selected pwm_denetleyici threshold register.
module pwm_sira_yoneticisi #(
  parameter int unsigned DERINLIK      = 8,
  parameter logic [5:0]  PWM_ESIK0_ADR = 6'h10,
  parameter logic [5:0]  PWM_ESIK1_ADR = 6'h18
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [5:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [5:0]  m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic [3:0]  m_sel_o,
  input  logic        m_ack_i
);

  localparam int unsigned IW         = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam int unsigned DW         = 32;
  localparam int unsigned XW         = 3;
  localparam logic [3:0]  DERINLIK_W = 4'(DERINLIK);

  localparam logic [5:0] ADR_KONTROL = 6'h00;
  localparam logic [5:0] ADR_ADIM    = 6'h04;
  localparam logic [5:0] ADR_UZUNLUK = 6'h08;
  localparam logic [5:0] ADR_DURUM   = 6'h0C;

  typedef enum logic [1:0] {BOSTA, YAZ, BEKLE, DUR} durum_e;

  durum_e          durum_q;
  logic            basla_q, tekrar_q, kanal_q, mesgul_q, hata_q, yeniden_q;
  logic [XW-1:0]   indeks_q;
  logic [DW-1:0]   sayac_q, adim_sure_q;
  logic [3:0]      uzunluk_q;
  logic [DW-1:0]   tablo_q [DERINLIK];

  logic            erisim_c, yaz_c, kontrol_yaz_c, tablo_sec_c;
  logic [IW-1:0]   tablo_k_c;
  logic            baslat_c, basla_yeni_c, kanal_yeni_c, son_adim_c;
  logic [DW-1:0]   sayac_yuk_c, oku_c;
  logic [5:0]      hedef_adr_c;
  logic [XW-1:0]   sonraki_idx_c;

  assign m_we_o  = 1'b1;
  assign m_sel_o = 4'hF;

  // Slave access decode; the !ack gate makes every write land exactly once.
  assign erisim_c      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign yaz_c         = erisim_c & wb_we_i;
  assign kontrol_yaz_c = yaz_c & (wb_adr_i == ADR_KONTROL) & wb_sel_i[0];
  assign tablo_sec_c   = wb_adr_i[5] & (wb_adr_i[1:0] == 2'b00) &
                         (32'(wb_adr_i[4:2]) < DERINLIK);
  assign tablo_k_c     = wb_adr_i[IW+1:2];

  // Control bits written this cycle take effect immediately for the sequencer.
  assign baslat_c     = kontrol_yaz_c & wb_dat_i[0];
  assign basla_yeni_c = kontrol_yaz_c ? wb_dat_i[0] : basla_q;
  assign kanal_yeni_c = kontrol_yaz_c ? wb_dat_i[2] : kanal_q;
  assign hedef_adr_c  = kanal_yeni_c ? PWM_ESIK1_ADR : PWM_ESIK0_ADR;
  assign sayac_yuk_c  = (adim_sure_q == '0) ? DW'(1) : adim_sure_q;
  assign son_adim_c   = ({1'b0, indeks_q} == (uzunluk_q - 4'd1));

  function automatic logic [DW-1:0] bayt_maske(input logic [DW-1:0] eski,
                                               input logic [DW-1:0] yeni,
                                               input logic [3:0]    sel);
    logic [DW-1:0] s;
    s = eski;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) s[8*b +: 8] = yeni[8*b +: 8];
    end
    return s;
  endfunction

  // Index of the entry the next launched write will carry.
  always_comb begin
    sonraki_idx_c = '0;
    if (durum_q == BEKLE && !yeniden_q && !baslat_c && !son_adim_c)
      sonraki_idx_c = XW'(indeks_q + XW'(1));
  end

  always_comb begin
    oku_c = '0;
    case (wb_adr_i)
      ADR_KONTROL: oku_c = {29'd0, kanal_q, tekrar_q, basla_q};
      ADR_ADIM:    oku_c = adim_sure_q;
      ADR_UZUNLUK: oku_c = {28'd0, uzunluk_q};
      ADR_DURUM:   oku_c = {25'd0, indeks_q, 2'b00, hata_q, mesgul_q};
      default:     if (tablo_sec_c) oku_c = tablo_q[tablo_k_c];
    endcase
  end

  // Slave register file and handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      adim_sure_q <= '0;
      uzunluk_q   <= '0;
      tekrar_q    <= 1'b0;
      kanal_q     <= 1'b0;
      for (int k = 0; k < DERINLIK; k++) tablo_q[k] <= '0;
    end else begin
      wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
      if (erisim_c) wb_dat_o <= oku_c;
      if (yaz_c) begin
        case (wb_adr_i)
          ADR_KONTROL: if (wb_sel_i[0]) begin
            tekrar_q <= wb_dat_i[1];
            kanal_q  <= wb_dat_i[2];
          end
          ADR_ADIM:    adim_sure_q <= bayt_maske(adim_sure_q, wb_dat_i, wb_sel_i);
          ADR_UZUNLUK: if (wb_sel_i[0] && !mesgul_q) uzunluk_q <= wb_dat_i[3:0];
          default:     if (tablo_sec_c)
                         tablo_q[tablo_k_c] <= bayt_maske(tablo_q[tablo_k_c], wb_dat_i, wb_sel_i);
        endcase
      end
    end
  end

  // Sequencer FSM and master port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q   <= BOSTA;
      basla_q   <= 1'b0;
      mesgul_q  <= 1'b0;
      hata_q    <= 1'b0;
      yeniden_q <= 1'b0;
      indeks_q  <= '0;
      sayac_q   <= '0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
    end else begin
      if (kontrol_yaz_c) basla_q <= wb_dat_i[0];
      if (kontrol_yaz_c && mesgul_q) yeniden_q <= wb_dat_i[0];
      case (durum_q)
        BOSTA: begin
          yeniden_q <= 1'b0;
          if (baslat_c) begin
            if (uzunluk_q == 4'd0 || uzunluk_q > DERINLIK_W) begin
              hata_q  <= 1'b1;
              basla_q <= 1'b0;
            end else begin
              hata_q   <= 1'b0;
              mesgul_q <= 1'b1;
              indeks_q <= sonraki_idx_c;
              m_cyc_o  <= 1'b1;
              m_stb_o  <= 1'b1;
              m_adr_o  <= hedef_adr_c;
              m_dat_o  <= tablo_q[sonraki_idx_c[IW-1:0]];
              durum_q  <= YAZ;
            end
          end
        end
        YAZ: begin
          if (m_ack_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            sayac_q <= sayac_yuk_c;
            durum_q <= basla_yeni_c ? BEKLE : DUR;
          end
        end
        BEKLE: begin
          if (!basla_yeni_c) begin
            durum_q <= DUR;
          end else if (yeniden_q || baslat_c || sayac_q <= DW'(1)) begin
            if (!yeniden_q && !baslat_c && son_adim_c && !tekrar_q) begin
              durum_q <= DUR;
            end else begin
              yeniden_q <= 1'b0;
              indeks_q  <= sonraki_idx_c;
              m_cyc_o   <= 1'b1;
              m_stb_o   <= 1'b1;
              m_adr_o   <= hedef_adr_c;
              m_dat_o   <= tablo_q[sonraki_idx_c[IW-1:0]];
              durum_q   <= YAZ;
            end
          end else begin
            sayac_q <= sayac_q - DW'(1);
          end
        end
        DUR: begin
          mesgul_q  <= 1'b0;
          basla_q   <= 1'b0;
          yeniden_q <= 1'b0;
          durum_q   <= BOSTA;
        end
        default: durum_q <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_sira_yoneticisi.sv
// Bench for pwm_sira_yoneticisi: CPU-side bus driver, a pwm_denetleyici-like
// slave with programmable ack delay, and a write monitor checked against table arithmetic.
module tb_pwm_sira_yoneticisi;
  localparam int unsigned DER = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [5:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [5:0]  m_adr_o;
  logic [31:0] m_dat_o;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic [3:0]  m_sel_o;
  logic        m_ack_i;

  pwm_sira_yoneticisi #(.DERINLIK(DER)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_sel_o(m_sel_o), .m_ack_i(m_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int lat = 1;
  int sl_cnt = 0;
  int son_yaz_cyc = 0;
  logic [31:0] model_tablo [DER];

  typedef struct {
    int          bas;
    int          ack;
    logic [5:0]  adr;
    logic [31:0] dat;
  } yazma_t;
  yazma_t wq[$];
  logic onceki_cyc = 1'b0;

  always @(posedge clk_i) cyc_cnt++;

  // Target slave: acks on the (lat+1)-th cycle of an active request.
  initial begin
    m_ack_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_ni || !(m_cyc_o && m_stb_o)) begin
        m_ack_i = 1'b0;
        sl_cnt  = 0;
      end else begin
        sl_cnt++;
        m_ack_i = (sl_cnt == lat + 1);
      end
    end
  end

  // Master-side monitor: logs each write and checks it is held stable until ack.
  always @(negedge clk_i) begin
    yazma_t y;
    if (m_cyc_o && m_stb_o) begin
      if (!onceki_cyc) begin
        y.bas = cyc_cnt; y.ack = -1; y.adr = m_adr_o; y.dat = m_dat_o;
        wq.push_back(y);
        checks++;
        if (m_we_o !== 1'b1 || m_sel_o !== 4'hF) begin
          errors++;
          $display("FAIL master_we_sel got we=%b sel=%h want we=1 sel=f", m_we_o, m_sel_o);
        end
      end else begin
        checks++;
        if (m_adr_o !== wq[wq.size()-1].adr || m_dat_o !== wq[wq.size()-1].dat) begin
          errors++;
          $display("FAIL master_stable got adr=%h dat=%h want adr=%h dat=%h",
                   m_adr_o, m_dat_o, wq[wq.size()-1].adr, wq[wq.size()-1].dat);
        end
      end
      if (m_ack_i) wq[wq.size()-1].ack = cyc_cnt;
    end
    onceki_cyc = m_cyc_o && m_stb_o;
  end

  task automatic wb_yaz(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk_i); #1;
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      if (wb_ack_o) break;
    end
    son_yaz_cyc = cyc_cnt;
    checks++;
    if (wb_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL wb_write_ack adr=%h got=%b want=1", a, wb_ack_o);
    end
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_oku(input logic [5:0] a, output logic [31:0] d);
    @(posedge clk_i); #1;
    wb_adr_i = a; wb_sel_i = 4'hF; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      if (wb_ack_o) break;
    end
    d = wb_dat_o;
    checks++;
    if (wb_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL wb_read_ack adr=%h got=%b want=1", a, wb_ack_o);
    end
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic oku_bekle(input string ad, input logic [5:0] a, input logic [31:0] m,
                           input logic [31:0] beklenen);
    logic [31:0] d;
    wb_oku(a, d);
    checks++;
    if ((d & m) !== beklenen) begin
      errors++;
      $display("FAIL %s adr=%h got=%h want=%h", ad, a, d & m, beklenen);
    end
  endtask

  task automatic bekle_yazma(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (wq.size() >= n) break;
      @(negedge clk_i);
    end
    checks++;
    if (wq.size() < n) begin
      errors++;
      $display("FAIL write_timeout got=%0d writes want=%0d", wq.size(), n);
    end
  endtask

  task automatic bosta_bekle();
    logic [31:0] d;
    d = 32'h1;
    for (int i = 0; i < 80; i++) begin
      wb_oku(6'h0C, d);
      if (d[0] == 1'b0) break;
    end
    checks++;
    if (d[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout got mesgul=%b want=0", d[0]);
    end
  endtask

  // One non-repeating pass; expectations follow from table order and step arithmetic.
  task automatic tek_gecis(input int l, input int as, input int len, input logic kn);
    int per;
    lat = l;
    for (int k = 0; k < len; k++) wb_yaz(6'h20 + 6'(4*k), model_tablo[k], 4'hF);
    wb_yaz(6'h04, 32'(as), 4'hF);
    wb_yaz(6'h08, 32'(len), 4'hF);
    wq.delete();
    wb_yaz(6'h00, {29'd0, kn, 1'b0, 1'b1}, 4'hF);
    per = (as == 0 ? 1 : as) + l + 1;
    bekle_yazma(len, len * per + 40);
    bosta_bekle();
    repeat (3 * per + 10) @(negedge clk_i);
    checks++;
    if (wq.size() != len) begin
      errors++;
      $display("FAIL write_count got=%0d want=%0d", wq.size(), len);
    end
    for (int i = 0; i < wq.size() && i < len; i++) begin
      checks++;
      if (wq[i].adr !== (kn ? 6'h18 : 6'h10) || wq[i].dat !== model_tablo[i]) begin
        errors++;
        $display("FAIL write_%0d got adr=%h dat=%h want adr=%h dat=%h", i,
                 wq[i].adr, wq[i].dat, kn ? 6'h18 : 6'h10, model_tablo[i]);
      end
      checks++;
      if (wq[i].ack - wq[i].bas != l) begin
        errors++;
        $display("FAIL ack_latency_%0d got=%0d want=%0d", i, wq[i].ack - wq[i].bas, l);
      end
      if (i > 0) begin
        checks++;
        if (wq[i].bas - wq[i-1].bas != per) begin
          errors++;
          $display("FAIL step_period_%0d got=%0d want=%0d", i, wq[i].bas - wq[i-1].bas, per);
        end
        checks++;
        if (wq[i].bas - wq[i-1].ack != per - l) begin
          errors++;
          $display("FAIL ack_to_next_%0d got=%0d want=%0d", i, wq[i].bas - wq[i-1].ack, per - l);
        end
      end
    end
    oku_bekle("durum_after_run", 6'h0C, 32'h3, 32'h0);
    oku_bekle("kontrol_after_run", 6'h00, 32'hFFFF_FFFF, {29'd0, kn, 2'b00});
  endtask

  task automatic test_reset();
    checks++;
    if ({wb_ack_o, wb_dat_o, m_cyc_o, m_stb_o, m_adr_o, m_dat_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b dat=%h cyc=%b stb=%b madr=%h mdat=%h want all 0",
               wb_ack_o, wb_dat_o, m_cyc_o, m_stb_o, m_adr_o, m_dat_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    oku_bekle("reset_kontrol", 6'h00, 32'hFFFF_FFFF, 32'h0);
    oku_bekle("reset_adim", 6'h04, 32'hFFFF_FFFF, 32'h0);
    oku_bekle("reset_uzunluk", 6'h08, 32'hFFFF_FFFF, 32'h0);
    oku_bekle("reset_durum", 6'h0C, 32'hFFFF_FFFF, 32'h0);
    for (int k = 0; k < DER; k++) oku_bekle("reset_tablo", 6'h20 + 6'(4*k), 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic test_hata();
    wq.delete();
    wb_yaz(6'h00, 32'h1, 4'hF);
    repeat (10) @(negedge clk_i);
    oku_bekle("hata_len0_durum", 6'h0C, 32'hFFFF_FFFF, 32'h2);
    oku_bekle("hata_len0_kontrol", 6'h00, 32'hFFFF_FFFF, 32'h0);
    wb_yaz(6'h08, 32'h9, 4'hF);
    wb_yaz(6'h00, 32'h1, 4'hF);
    repeat (10) @(negedge clk_i);
    oku_bekle("hata_len9_durum", 6'h0C, 32'h3, 32'h2);
    oku_bekle("hata_len9_uzunluk", 6'h08, 32'hFFFF_FFFF, 32'h9);
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL hata_no_master got=%0d writes want=0", wq.size());
    end
  endtask

  task automatic test_bayt();
    wb_yaz(6'h04, 32'h1234_5678, 4'b0101);
    oku_bekle("sel_mask_adim", 6'h04, 32'hFFFF_FFFF, 32'h0034_0078);
    wb_yaz(6'h14, 32'hFFFF_FFFF, 4'hF);
    oku_bekle("unmapped_read", 6'h14, 32'hFFFF_FFFF, 32'h0);
    oku_bekle("misaligned_read", 6'h22, 32'hFFFF_FFFF, 32'h0);
    wb_yaz(6'h00, 32'h7, 4'b1110);
    oku_bekle("kontrol_byte0_only", 6'h00, 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic test_sira();
    model_tablo[0] = 32'd10; model_tablo[1] = 32'd20; model_tablo[2] = 32'd30;
    tek_gecis(1, 5, 3, 1'b0);
  endtask

  task automatic test_tekrar();
    int n;
    model_tablo[0] = 32'd10; model_tablo[1] = 32'd20; model_tablo[2] = 32'd30;
    lat = 1;
    for (int k = 0; k < 3; k++) wb_yaz(6'h20 + 6'(4*k), model_tablo[k], 4'hF);
    wb_yaz(6'h04, 32'd5, 4'hF);
    wb_yaz(6'h08, 32'd3, 4'hF);
    wq.delete();
    wb_yaz(6'h00, 32'h3, 4'hF);
    bekle_yazma(5, 200);
    wb_yaz(6'h00, 32'h2, 4'hF);
    bosta_bekle();
    n = wq.size();
    repeat (30) @(negedge clk_i);
    checks++;
    if (wq.size() != n) begin
      errors++;
      $display("FAIL abort_no_new got=%0d writes want=%0d", wq.size(), n);
    end
    for (int i = 0; i < wq.size(); i++) begin
      checks++;
      if (wq[i].dat !== model_tablo[i % 3] || wq[i].adr !== 6'h10 || wq[i].ack < 0) begin
        errors++;
        $display("FAIL repeat_write_%0d got dat=%h adr=%h ack=%0d want dat=%h adr=10 acked",
                 i, wq[i].dat, wq[i].adr, wq[i].ack, model_tablo[i % 3]);
      end
    end
    oku_bekle("abort_kontrol", 6'h00, 32'hFFFF_FFFF, 32'h2);
  endtask

  task automatic test_kanal();
    model_tablo[0] = $urandom;
    tek_gecis(4, 2, 1, 1'b1);
  endtask

  task automatic test_adim_sifir();
    model_tablo[0] = $urandom; model_tablo[1] = $urandom;
    tek_gecis(1, 0, 2, 1'b0);
  endtask

  task automatic test_rastgele();
    for (int it = 0; it < 5; it++) begin
      int len;
      len = (it == 0) ? DER : $urandom_range(1, DER);
      for (int k = 0; k < DER; k++) model_tablo[k] = $urandom;
      tek_gecis($urandom_range(0, 3), $urandom_range(0, 4), len, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    int rs, j, adet;
    for (int k = 0; k < 4; k++) begin
      model_tablo[k] = $urandom;
      wb_yaz(6'h20 + 6'(4*k), model_tablo[k], 4'hF);
    end
    lat = 1;
    wb_yaz(6'h04, 32'd3, 4'hF);
    wb_yaz(6'h08, 32'd4, 4'hF);
    wq.delete();
    wb_yaz(6'h00, 32'h3, 4'hF);
    bekle_yazma(3, 100);
    wb_yaz(6'h08, 32'd1, 4'hF);
    oku_bekle("uzunluk_locked", 6'h08, 32'hFFFF_FFFF, 32'd4);
    wb_yaz(6'h00, 32'h3, 4'hF);
    rs = son_yaz_cyc;
    repeat (40) @(negedge clk_i);
    wb_yaz(6'h00, 32'h0, 4'hF);
    bosta_bekle();
    j = 0;
    while (j < wq.size() && wq[j].bas < rs) j++;
    adet = wq.size() - j;
    checks++;
    if (adet < 3) begin
      errors++;
      $display("FAIL restart_writes got=%0d want>=3", adet);
    end
    for (int i = 0; i < adet; i++) begin
      checks++;
      if (wq[j+i].dat !== model_tablo[i % 4]) begin
        errors++;
        $display("FAIL restart_seq_%0d got=%h want=%h", i, wq[j+i].dat, model_tablo[i % 4]);
      end
    end
  endtask

  task automatic test_reset_mid();
    model_tablo[0] = $urandom; model_tablo[1] = $urandom;
    lat = 4;
    for (int k = 0; k < 2; k++) wb_yaz(6'h20 + 6'(4*k), model_tablo[k], 4'hF);
    wb_yaz(6'h04, 32'd3, 4'hF);
    wb_yaz(6'h08, 32'd2, 4'hF);
    wb_yaz(6'h00, 32'h1, 4'hF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (m_cyc_o) break;
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({m_cyc_o, m_stb_o, m_adr_o, m_dat_o, wb_ack_o} !== '0) begin
      errors++;
      $display("FAIL async_reset got cyc=%b stb=%b adr=%h dat=%h ack=%b want all 0",
               m_cyc_o, m_stb_o, m_adr_o, m_dat_o, wb_ack_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    wq.delete();
    oku_bekle("mid_reset_kontrol", 6'h00, 32'hFFFF_FFFF, 32'h0);
    oku_bekle("mid_reset_adim", 6'h04, 32'hFFFF_FFFF, 32'h0);
    oku_bekle("mid_reset_uzunluk", 6'h08, 32'hFFFF_FFFF, 32'h0);
    oku_bekle("mid_reset_durum", 6'h0C, 32'hFFFF_FFFF, 32'h0);
    for (int k = 0; k < DER; k++) oku_bekle("mid_reset_tablo", 6'h20 + 6'(4*k), 32'hFFFF_FFFF, 32'h0);
    repeat (20) @(negedge clk_i);
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_idle got=%0d writes want=0", wq.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_sel_i = '0;
    for (int k = 0; k < DER; k++) model_tablo[k] = '0;
    repeat (3) @(negedge clk_i);
    test_reset();
    test_hata();
    test_bayt();
    test_sira();
    test_tekrar();
    test_kanal();
    test_adim_sifir();
    test_back_to_back();
    test_rastgele();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
